// File: rtl/sc_pkg.sv
// Shared types for the charge scheduler:
// grid conditions, per-port states, capacity lookup.
package sc_pkg;

  typedef enum logic [1:0] {
    GRID_NORMAL = 2'd0,
    GRID_SAG    = 2'd1,
    GRID_SWELL  = 2'd2,
    GRID_OUTAGE = 2'd3
  } grid_state_t;

  typedef enum logic [1:0] {
    PORT_OFF      = 2'd0,
    PORT_CLOSING  = 2'd1,
    PORT_CHARGING = 2'd2,
    PORT_OPENING  = 2'd3
  } port_state_t;

  function automatic int grid_capacity(
    input grid_state_t g,
    input int          n
  );
    case (g)
      GRID_NORMAL: return n;
      GRID_SAG:    return n / 2;
      GRID_SWELL:  return 1;
      default:     return 0;
    endcase
  endfunction

endpackage

// File: rtl/sc_port_fsm.sv
// One charging port: contactor sequencing with
// settle timing and a saturating fairness slice.
module sc_port_fsm
  import sc_pkg::*;
#(
  parameter int SETTLE_CYC = 8,
  parameter int SLICE_CYC  = 1024
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        fault,
  input  logic        req,
  input  logic        grant,
  input  logic        revoke,
  output port_state_t state,
  output logic        active_nxt,
  output logic        slice_done,
  output logic        relay,
  output logic        enable
);

  localparam int SW = $clog2(SETTLE_CYC + 1);
  localparam int LW = $clog2(SLICE_CYC + 1);

  port_state_t   nxt;
  logic [SW-1:0] settle, settle_nxt;
  logic [LW-1:0] slice, slice_nxt;
  logic          settle_end;
  logic          leave;

  assign settle_end = (settle == SW'(SETTLE_CYC - 1));
  assign leave      = !req || revoke;

  always_comb begin
    nxt        = state;
    settle_nxt = settle;
    slice_nxt  = slice;
    if (fault) begin
      nxt        = PORT_OFF;
      settle_nxt = '0;
      slice_nxt  = '0;
    end else begin
      unique case (state)
        PORT_OFF: begin
          if (grant) begin
            nxt        = PORT_CLOSING;
            settle_nxt = '0;
          end
        end
        PORT_CLOSING: begin
          if (leave) begin
            nxt        = PORT_OPENING;
            settle_nxt = '0;
          end else if (settle_end) begin
            nxt       = PORT_CHARGING;
            slice_nxt = '0;
          end else begin
            settle_nxt = settle + SW'(1);
          end
        end
        PORT_CHARGING: begin
          if (leave) begin
            nxt        = PORT_OPENING;
            settle_nxt = '0;
          end else if (slice != LW'(SLICE_CYC)) begin
            slice_nxt = slice + LW'(1);
          end
        end
        PORT_OPENING: begin
          if (settle_end) begin
            nxt        = PORT_OFF;
            settle_nxt = '0;
          end else begin
            settle_nxt = settle + SW'(1);
          end
        end
        default: nxt = PORT_OFF;
      endcase
    end
  end

  assign active_nxt = (nxt == PORT_CLOSING) ||
                      (nxt == PORT_CHARGING);
  assign slice_done = (state == PORT_CHARGING) &&
                      (slice == LW'(SLICE_CYC));

  // Outputs come from next state so they align with state.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state  <= PORT_OFF;
      settle <= '0;
      slice  <= '0;
      relay  <= 1'b0;
      enable <= 1'b0;
    end else begin
      state  <= nxt;
      settle <= settle_nxt;
      slice  <= slice_nxt;
      relay  <= (nxt != PORT_OFF);
      enable <= (nxt == PORT_CHARGING);
    end
  end

endmodule

// File: rtl/charge_scheduler.sv
// Shared-grid charge scheduler: capacity revoke,
// fairness pre-emption and round-robin grants.
module charge_scheduler
  import sc_pkg::*;
#(
  parameter int N_PORTS    = 4,
  parameter int SETTLE_CYC = 8,
  parameter int SLICE_CYC  = 1024
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  grid_state_t                  grid_state,
  input  logic                         fault_flag,
  input  logic [N_PORTS-1:0]           port_req,
  output logic [N_PORTS-1:0]           charge_enable,
  output logic [N_PORTS-1:0]           relay_activation,
  output logic [$clog2(N_PORTS+1)-1:0] active_count
);

  localparam int CW = $clog2(N_PORTS + 1);
  localparam int PW = (N_PORTS > 1) ? $clog2(N_PORTS) : 1;

  port_state_t        st [N_PORTS];
  logic [N_PORTS-1:0] active, idle, active_nxt;
  logic [N_PORTS-1:0] slice_done, grant, revoke;
  logic [PW-1:0]      rr_ptr, rr_nxt, idx;
  logic [CW-1:0]      cap, count_nxt;
  logic               found, waiting;

  for (genvar i = 0; i < N_PORTS; i++) begin : g_port
    sc_port_fsm #(
      .SETTLE_CYC (SETTLE_CYC),
      .SLICE_CYC  (SLICE_CYC)
    ) u_port (
      .clk        (clk),
      .reset_n    (reset_n),
      .fault      (fault_flag),
      .req        (port_req[i]),
      .grant      (grant[i]),
      .revoke     (revoke[i]),
      .state      (st[i]),
      .active_nxt (active_nxt[i]),
      .slice_done (slice_done[i]),
      .relay      (relay_activation[i]),
      .enable     (charge_enable[i])
    );
    assign active[i] = (st[i] == PORT_CLOSING) ||
                       (st[i] == PORT_CHARGING);
    assign idle[i]   = (st[i] == PORT_OFF);
  end

  assign cap     = CW'(grid_capacity(grid_state, N_PORTS));
  assign waiting = |(idle & port_req);

  // The three branches are exclusive by count vs capacity.
  always_comb begin
    grant  = '0;
    revoke = '0;
    rr_nxt = rr_ptr;
    idx    = '0;
    found  = 1'b0;
    if (!fault_flag) begin
      if (active_count > cap) begin
        for (int k = N_PORTS - 1; k >= 0; k--) begin
          if (!found && active[k]) begin
            revoke[k] = 1'b1;
            found     = 1'b1;
          end
        end
      end else if (active_count == cap && cap != '0 && waiting) begin
        for (int k = 0; k < N_PORTS; k++) begin
          if (!found && slice_done[k]) begin
            revoke[k] = 1'b1;
            found     = 1'b1;
          end
        end
      end else if (active_count < cap) begin
        for (int k = 0; k < N_PORTS; k++) begin
          idx = PW'((int'(rr_ptr) + k) % N_PORTS);
          if (!found && idle[idx] && port_req[idx]) begin
            grant[idx] = 1'b1;
            rr_nxt     = PW'((int'(idx) + 1) % N_PORTS);
            found      = 1'b1;
          end
        end
      end
    end
  end

  always_comb begin
    count_nxt = '0;
    for (int k = 0; k < N_PORTS; k++) begin
      count_nxt = count_nxt + CW'(active_nxt[k]);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rr_ptr       <= '0;
      active_count <= '0;
    end else begin
      rr_ptr       <= rr_nxt;
      active_count <= count_nxt;
    end
  end

endmodule

// File: tb/tb_charge_scheduler.sv
// Self-checking bench for charge_scheduler:
// cycle vector table plus slice and async-reset sequences.
module tb_charge_scheduler;
  import sc_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n;
  grid_state_t grid_state;
  logic        fault_flag;
  logic [3:0]  port_req;
  logic [3:0]  charge_enable;
  logic [3:0]  relay_activation;
  logic [2:0]  active_count;

  charge_scheduler #(
    .N_PORTS    (4),
    .SETTLE_CYC (8),
    .SLICE_CYC  (1024)
  ) dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .grid_state       (grid_state),
    .fault_flag       (fault_flag),
    .port_req         (port_req),
    .charge_enable    (charge_enable),
    .relay_activation (relay_activation),
    .active_count     (active_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    grid_state_t grid;
    logic        fault;
    logic [3:0]  req;
    logic [3:0]  relay;
    logic [3:0]  en;
    logic [2:0]  cnt;
  } vec_t;

  typedef struct {
    logic [3:0] relay;
    logic [3:0] en;
    logic [2:0] cnt;
  } exp_t;

  vec_t vecs[$];
  exp_t sbq[$];
  int   checks   = 0;
  int   failures = 0;

  function automatic void add(
    input logic rst, input grid_state_t g, input logic f,
    input logic [3:0] rq, input logic [3:0] rl,
    input logic [3:0] en, input logic [2:0] c, input int reps
  );
    vec_t v;
    v.rst = rst; v.grid = g; v.fault = f; v.req = rq;
    v.relay = rl; v.en = en; v.cnt = c;
    for (int r = 0; r < reps; r++) vecs.push_back(v);
  endfunction

  task automatic check(
    input string name, input logic [3:0] act,
    input logic [3:0] exp
  );
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %b want %b", name, act, exp);
    end
  endtask

  task automatic check_out(
    input string tag, input logic [3:0] rl,
    input logic [3:0] en, input logic [2:0] c
  );
    check({tag, "_relay"}, relay_activation, rl);
    check({tag, "_en"}, charge_enable, en);
    check({tag, "_cnt"}, {1'b0, active_count}, {1'b0, c});
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    exp_t e;
    reset_n    = 1'b0;
    grid_state = GRID_NORMAL;
    fault_flag = 1'b0;
    port_req   = 4'b0000;

    // reset
    add(0, GRID_NORMAL, 0, 4'b0000, 4'b0000, 4'b0000, 3'd0, 2);
    // all request: staggered grants, enable 8 after relay
    add(1, GRID_NORMAL, 0, 4'b1111, 4'b0001, 4'b0000, 3'd1, 1);
    add(1, GRID_NORMAL, 0, 4'b1111, 4'b0011, 4'b0000, 3'd2, 1);
    add(1, GRID_NORMAL, 0, 4'b1111, 4'b0111, 4'b0000, 3'd3, 1);
    add(1, GRID_NORMAL, 0, 4'b1111, 4'b1111, 4'b0000, 3'd4, 5);
    add(1, GRID_NORMAL, 0, 4'b1111, 4'b1111, 4'b0001, 3'd4, 1);
    add(1, GRID_NORMAL, 0, 4'b1111, 4'b1111, 4'b0011, 3'd4, 1);
    add(1, GRID_NORMAL, 0, 4'b1111, 4'b1111, 4'b0111, 3'd4, 1);
    add(1, GRID_NORMAL, 0, 4'b1111, 4'b1111, 4'b1111, 3'd4, 1);
    // sag: revoke 3 then 2, relays drop 8 later
    add(1, GRID_SAG, 0, 4'b1111, 4'b1111, 4'b0111, 3'd3, 1);
    add(1, GRID_SAG, 0, 4'b1111, 4'b1111, 4'b0011, 3'd2, 7);
    add(1, GRID_SAG, 0, 4'b1111, 4'b0111, 4'b0011, 3'd2, 1);
    add(1, GRID_SAG, 0, 4'b1111, 4'b0011, 4'b0011, 3'd2, 3);
    // sag from reset: grants stop at two
    add(0, GRID_SAG, 0, 4'b1111, 4'b0000, 4'b0000, 3'd0, 1);
    add(1, GRID_SAG, 0, 4'b1111, 4'b0001, 4'b0000, 3'd1, 1);
    add(1, GRID_SAG, 0, 4'b1111, 4'b0011, 4'b0000, 3'd2, 3);
    // fault: immediate off, held, re-grant, rr kept
    add(0, GRID_NORMAL, 0, 4'b0010, 4'b0000, 4'b0000, 3'd0, 1);
    add(1, GRID_NORMAL, 0, 4'b0010, 4'b0010, 4'b0000, 3'd1, 8);
    add(1, GRID_NORMAL, 0, 4'b0010, 4'b0010, 4'b0010, 3'd1, 1);
    add(1, GRID_NORMAL, 1, 4'b0010, 4'b0000, 4'b0000, 3'd0, 2);
    add(1, GRID_NORMAL, 0, 4'b0010, 4'b0010, 4'b0000, 3'd1, 8);
    add(1, GRID_NORMAL, 0, 4'b0010, 4'b0010, 4'b0010, 3'd1, 1);
    add(1, GRID_NORMAL, 1, 4'b0110, 4'b0000, 4'b0000, 3'd0, 1);
    add(1, GRID_NORMAL, 0, 4'b0110, 4'b0100, 4'b0000, 3'd1, 1);
    add(1, GRID_NORMAL, 0, 4'b0110, 4'b0110, 4'b0000, 3'd2, 1);
    // req drop mid-closing; opening ignores req
    add(0, GRID_NORMAL, 0, 4'b0001, 4'b0000, 4'b0000, 3'd0, 1);
    add(1, GRID_NORMAL, 0, 4'b0001, 4'b0001, 4'b0000, 3'd1, 1);
    add(1, GRID_NORMAL, 0, 4'b0000, 4'b0001, 4'b0000, 3'd0, 1);
    add(1, GRID_NORMAL, 0, 4'b0001, 4'b0001, 4'b0000, 3'd0, 7);
    add(1, GRID_NORMAL, 0, 4'b0001, 4'b0000, 4'b0000, 3'd0, 1);
    add(1, GRID_NORMAL, 0, 4'b0001, 4'b0001, 4'b0000, 3'd1, 1);
    // outage: nothing granted, then recovery
    add(0, GRID_OUTAGE, 0, 4'b1111, 4'b0000, 4'b0000, 3'd0, 1);
    add(1, GRID_OUTAGE, 0, 4'b1111, 4'b0000, 4'b0000, 3'd0, 10);
    add(1, GRID_NORMAL, 0, 4'b1111, 4'b0001, 4'b0000, 3'd1, 1);

    #2;
    check_out("reset_hold", 4'b0000, 4'b0000, 3'd0);

    foreach (vecs[i]) begin
      reset_n    = vecs[i].rst;
      grid_state = vecs[i].grid;
      fault_flag = vecs[i].fault;
      port_req   = vecs[i].req;
      e.relay = vecs[i].relay;
      e.en    = vecs[i].en;
      e.cnt   = vecs[i].cnt;
      sbq.push_back(e);
      tick();
      e = sbq.pop_front();
      check_out($sformatf("v%0d", i), e.relay, e.en, e.cnt);
    end

    // swell: slice pre-emption hands the single slot over
    reset_n    = 1'b0;
    fault_flag = 1'b0;
    tick();
    reset_n    = 1'b1;
    grid_state = GRID_SWELL;
    port_req   = 4'b0101;
    tick();
    check_out("sw_grant0", 4'b0001, 4'b0000, 3'd1);
    tick();
    check_out("sw_full", 4'b0001, 4'b0000, 3'd1);
    repeat (1031) tick();
    check_out("sw_last_slice", 4'b0001, 4'b0001, 3'd1);
    tick();
    check_out("sw_preempt", 4'b0001, 4'b0000, 3'd0);
    tick();
    check_out("sw_grant2", 4'b0101, 4'b0000, 3'd1);
    repeat (7) tick();
    check_out("sw_p0_off", 4'b0100, 4'b0000, 3'd1);
    tick();
    check_out("sw_p2_chg", 4'b0100, 4'b0100, 3'd1);

    // asynchronous reset during closing
    reset_n = 1'b0;
    tick();
    reset_n    = 1'b1;
    grid_state = GRID_NORMAL;
    port_req   = 4'b0001;
    repeat (3) tick();
    check_out("ar_closing", 4'b0001, 4'b0000, 3'd1);
    #2;
    reset_n = 1'b0;
    #1;
    check_out("ar_async", 4'b0000, 4'b0000, 3'd0);
    port_req = 4'b0000;
    tick();
    check_out("ar_held", 4'b0000, 4'b0000, 3'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/charge_scheduler.md
CHARGE_SCHEDULER -- requirements
Module: charge_scheduler

Interface
REQ-001 Parameter N_PORTS, default 4, number of charging ports sharing the grid connection.
REQ-002 Parameter SETTLE_CYC, default 8, relay settle time in cycles between relay and enable edges.
REQ-003 Parameter SLICE_CYC, default 1024, charging cycles after which a port may be pre-empted for fairness.
REQ-004 clk  input  1  single system clock, all state updates on rising edge.
REQ-005 reset_n  input  1  reset, asynchronous, active-low.
REQ-006 grid_state  input  grid_state_t  current grid condition from grid monitor.
REQ-007 fault_flag  input  1  safety-block fault indication, high = fault present.
REQ-008 port_req  input  N_PORTS  per-port charge request, level-sensitive.
REQ-009 charge_enable  output  N_PORTS  per-port charge current enable.
REQ-010 relay_activation  output  N_PORTS  per-port contactor relay drive.
REQ-011 active_count  output  $clog2(N_PORTS+1)  number of ports in CLOSING or CHARGING.

Function
REQ-012 Each port SHALL run its own FSM with states OFF, CLOSING, CHARGING, OPENING; all outputs registered.
REQ-013 Outputs per state: OFF relay=0 en=0; CLOSING relay=1 en=0; CHARGING relay=1 en=1; OPENING relay=1 en=0.
REQ-014 CLOSING SHALL last exactly SETTLE_CYC cycles, then go to CHARGING; OPENING SHALL last exactly SETTLE_CYC cycles, then go to OFF.
REQ-015 Capacity SHALL be: GRID_NORMAL=N_PORTS, GRID_SAG=N_PORTS/2, GRID_SWELL=1, GRID_OUTAGE=0.
REQ-016 At most one new grant per cycle: an OFF port with port_req=1 moves to CLOSING only if active_count < capacity.
REQ-017 Grant selection SHALL be round-robin from rr_ptr; after a grant rr_ptr = granted index + 1 modulo N_PORTS.
REQ-018 A CLOSING or CHARGING port whose port_req drops SHALL move to OPENING next cycle (CLOSING aborts mid-count).
REQ-019 If active_count > capacity, exactly one port per cycle SHALL move to OPENING: the highest-index port in CLOSING/CHARGING; no grants that cycle.
REQ-020 Each CHARGING port SHALL have a slice counter, cleared on entering CHARGING, saturating at SLICE_CYC.
REQ-021 If any OFF port requests, active_count == capacity > 0, and a CHARGING port's counter == SLICE_CYC, the lowest such index SHALL move to OPENING (one per cycle).
REQ-022 A port in OPENING ignores port_req until it reaches OFF.
REQ-023 fault_flag=1 SHALL force every port to OFF on the next edge (relay=0, en=0, no OPENING sequence), held while fault_flag=1.
REQ-024 On fault_flag deassertion normal arbitration resumes the following cycle; rr_ptr is preserved across faults.
REQ-025 Simultaneous req-drop and capacity revoke on one port: the port enters OPENING once; the revoke counts as satisfied.
REQ-026 Priority per cycle: fault > capacity revoke > req-drop > slice pre-emption > new grant.

Reset
REQ-027 During reset_n=0 all ports SHALL be OFF, charge_enable=0, relay_activation=0, active_count=0, rr_ptr=0, counters=0.
REQ-028 Reset assertion mid-CLOSING/CHARGING/OPENING SHALL drop relay and enable immediately (asynchronously).

Structure
REQ-029 grid_state_t (GRID_NORMAL, GRID_SAG, GRID_SWELL, GRID_OUTAGE) and the per-port state enum SHALL live in the shared sc package.
REQ-030 Per-port FSM plus settle/slice counters SHALL be one sub-module, sc_port_fsm, instantiated N_PORTS times; arbitration stays in charge_scheduler.

Verification
REQ-031 NORMAL, port_req=4'b1111 from reset -> ports 0,1,2,3 enter CLOSING on consecutive cycles; each charge_enable rises 8 cycles after its relay.
REQ-032 4 ports CHARGING, grid_state -> GRID_SAG -> ports 3 then 2 enter OPENING on consecutive cycles; relays drop 8 cycles later; active_count=2.
REQ-033 Port 1 CHARGING, fault_flag pulse 1 cycle -> next edge all relay/enable 0; fault cleared -> port 1 re-granted, enable 8 cycles after relay.
REQ-034 GRID_SWELL, port 0 charging, port 2 requesting -> after 1024 charging cycles port 0 OPENING, port 2 CLOSING once port 0 leaves CHARGING.
REQ-035 GRID_OUTAGE with all requests high -> no relay ever asserts; active_count=0.
REQ-036 reset_n asserted while port 0 in CLOSING cycle 3 -> relay_activation[0]=0 immediately without clock edge.
